// File: rtl/bsg_fifo_credit_tx_pkg.sv
// bsg_fifo_credit_tx_pkg: shared state encoding and credit counter sizing helper
package bsg_fifo_credit_tx_pkg;
    typedef enum logic [1:0] {eIdle, eActive, eError} credit_tx_state_e;
    function automatic int credit_width(int els);
        return $clog2(els + 1);
    endfunction
endpackage

// File: rtl/bsg_fifo_credit_tx_if.sv
// bsg_fifo_credit_tx_if: producer handshake, outgoing link word and returning credit
interface bsg_fifo_credit_tx_if #(parameter int width_p = 16);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               credit_i;
    modport master (output v_i, data_i, credit_i, input ready_o, v_o, data_o);
    modport slave  (input v_i, data_i, credit_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bsg_credit_counter.sv
// bsg_credit_counter: up/down counter saturating at 0 and max_p, flags an up at max with no down
module bsg_credit_counter
    import bsg_fifo_credit_tx_pkg::*;
#(
    parameter int max_p       = 4,
    parameter int reset_val_p = max_p,
    parameter int width_p     = credit_width(max_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic [width_p-1:0] count_next_o,
    output logic               overflow_o
);
    localparam logic [width_p-1:0] max_lp   = width_p'(max_p);
    localparam logic [width_p-1:0] reset_lp = width_p'(reset_val_p);
    logic [width_p-1:0] count_q, count_d;
    logic               at_max, at_zero;
    always_comb begin
        at_max     = count_q == max_lp;
        at_zero    = count_q == '0;
        overflow_o = up_i & ~down_i & at_max;
        count_d    = (up_i & ~down_i) ? (at_max ? count_q : count_q + 1'b1)
                   : (down_i & ~up_i) ? (at_zero ? count_q : count_q - 1'b1)
                   : count_q;
    end
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) count_q <= reset_lp;
        else            count_q <= count_d;
    assign count_o      = count_q;
    assign count_next_o = count_d;
endmodule

// File: rtl/bsg_fifo_credit_tx.sv
// bsg_fifo_credit_tx: credit-gated link transmitter feeding a remote small FIFO
module bsg_fifo_credit_tx
    import bsg_fifo_credit_tx_pkg::*;
#(
    parameter  int width_p       = 16,
    parameter  int els_p         = 4,
    localparam int lg_credits_lp = credit_width(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_fifo_credit_tx_if.slave      link_if,
    output logic [lg_credits_lp-1:0] credits_o,
    output logic                     idle_o,
    output logic                     error_o
);
    credit_tx_state_e       state_q;
    logic                   v_q;
    logic [width_p-1:0]     data_q;
    logic                   ready, send, overflow;
    logic [lg_credits_lp-1:0] credits_next;
    bsg_credit_counter #(
        .max_p       (els_p),
        .reset_val_p (els_p),
        .width_p     (lg_credits_lp)
    ) counter (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .up_i         (link_if.credit_i),
        .down_i       (send),
        .count_o      (credits_o),
        .count_next_o (credits_next),
        .overflow_o   (overflow)
    );
    // ready comes from registers only, so a credit arriving now helps next cycle
    assign ready = (credits_o != '0) && (state_q != eError);
    assign send  = link_if.v_i & ready;
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state_q <= eIdle;
            v_q     <= 1'b0;
            data_q  <= '0;
        end else begin
            v_q    <= send;
            data_q <= send ? link_if.data_i : data_q;
            unique case (state_q)
                eIdle:   state_q <= overflow ? eError : send ? eActive : eIdle;
                eActive: state_q <= overflow ? eError
                                  : (credits_next == lg_credits_lp'(els_p)) ? eIdle : eActive;
                default: state_q <= eError;
            endcase
        end
    assign link_if.ready_o = ready;
    assign link_if.v_o     = v_q;
    assign link_if.data_o  = data_q;
    assign idle_o          = state_q == eIdle;
    assign error_o         = state_q == eError;
endmodule

// File: tb/tb_bsg_fifo_credit_tx.sv
// tb_bsg_fifo_credit_tx: directed checks plus a random soak against a remote FIFO model
module tb_bsg_fifo_credit_tx;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] credits;
    logic       idle, err;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [15:0] sb[$];
    logic [15:0] remote[$];
    logic [15:0] exp_word;
    int          mcred;
    logic        yumi, exp_send;

    bsg_fifo_credit_tx_if #(.width_p(16)) lif();

    bsg_fifo_credit_tx #(.width_p(16), .els_p(4)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .link_if   (lif),
        .credits_o (credits),
        .idle_o    (idle),
        .error_o   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        lif.v_i = 1'b0;
        lif.data_i = '0;
        lif.credit_i = 1'b0;
        #12;
        check("rst_ready", 32'(lif.ready_o), 1);
        check("rst_credits", 32'(credits), 4);
        check("rst_idle", 32'(idle), 1);
        check("rst_v", 32'(lif.v_o), 0);
        check("rst_data", 32'(lif.data_o), 0);
        check("rst_err", 32'(err), 0);
        reset_n = 1'b1;
        lif.v_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            lif.data_i = 16'(i);
            step();
            check("stream_v", 32'(lif.v_o), 1);
            check("stream_data", 32'(lif.data_o), 32'(i));
            check("stream_credits", 32'(credits), 32'(4 - i));
            check("stream_idle", 32'(idle), 0);
        end
        check("empty_ready", 32'(lif.ready_o), 0);
        lif.data_i = 16'h0005;
        step();
        check("held_v", 32'(lif.v_o), 0);
        check("held_data", 32'(lif.data_o), 4);
        check("held_credits", 32'(credits), 0);
        lif.credit_i = 1'b1;
        step();
        lif.credit_i = 1'b0;
        check("one_credit_cnt", 32'(credits), 1);
        check("one_credit_ready", 32'(lif.ready_o), 1);
        check("one_credit_v", 32'(lif.v_o), 0);
        step();
        check("word5_v", 32'(lif.v_o), 1);
        check("word5_data", 32'(lif.data_o), 5);
        check("word5_credits", 32'(credits), 0);
        lif.v_i = 1'b0;
        lif.credit_i = 1'b1;
        step();
        step();
        check("two_credits", 32'(credits), 2);
        lif.v_i = 1'b1;
        lif.data_i = 16'h00a5;
        step();
        check("simul_credits", 32'(credits), 2);
        check("simul_idle", 32'(idle), 0);
        check("simul_v", 32'(lif.v_o), 1);
        check("simul_data", 32'(lif.data_o), 32'h00a5);
        lif.v_i = 1'b0;
        step();
        step();
        check("home_credits", 32'(credits), 4);
        check("home_idle", 32'(idle), 1);
        check("home_err", 32'(err), 0);
        step();
        lif.credit_i = 1'b0;
        check("ovf_err", 32'(err), 1);
        check("ovf_ready", 32'(lif.ready_o), 0);
        check("ovf_credits", 32'(credits), 4);
        check("ovf_idle", 32'(idle), 0);
        lif.v_i = 1'b1;
        lif.data_i = 16'h0bad;
        step();
        check("ovf_no_send", 32'(lif.v_o), 0);
        check("ovf_data_hold", 32'(lif.data_o), 32'h00a5);
        lif.v_i = 1'b0;
        reset_n = 1'b0;
        #1;
        check("ovf_rst_err", 32'(err), 0);
        reset_n = 1'b1;
        lif.v_i = 1'b1;
        lif.data_i = 16'h1111;
        step();
        lif.data_i = 16'h2222;
        step();
        check("mid_credits", 32'(credits), 2);
        check("mid_v", 32'(lif.v_o), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_v", 32'(lif.v_o), 0);
        check("async_credits", 32'(credits), 4);
        check("async_data", 32'(lif.data_o), 0);
        lif.v_i = 1'b0;
        #1;
        reset_n = 1'b1;
        step();
        check("post_rst_idle", 32'(idle), 1);
        check("post_rst_ready", 32'(lif.ready_o), 1);
        mcred = 4;
        for (int c = 0; c < 400; c++) begin
            lif.v_i = ($urandom_range(0, 3) != 0);
            lif.data_i = 16'($urandom);
            yumi = (remote.size() > 0) && ($urandom_range(0, 2) != 0);
            lif.credit_i = yumi;
            exp_send = lif.v_i && (mcred != 0);
            if (exp_send) sb.push_back(lif.data_i);
            mcred = mcred - int'(exp_send) + int'(yumi);
            step();
            if (yumi) void'(remote.pop_front());
            check("soak_v", 32'(lif.v_o), 32'(exp_send));
            if (lif.v_o && sb.size() > 0) begin
                exp_word = sb.pop_front();
                check("soak_data", 32'(lif.data_o), 32'(exp_word));
                remote.push_back(lif.data_o);
            end
            check("soak_credits", 32'(credits), 32'(mcred));
            check("soak_ready", 32'(lif.ready_o), 32'(mcred != 0));
            check("soak_remote_fit", 32'(remote.size() <= 4), 1);
            check("soak_err", 32'(err), 0);
        end
        lif.v_i = 1'b0;
        for (int c = 0; c < 20 && remote.size() > 0; c++) begin
            lif.credit_i = 1'b1;
            step();
            void'(remote.pop_front());
        end
        lif.credit_i = 1'b0;
        check("drain_remote", 32'(remote.size()), 0);
        check("drain_sb", 32'(sb.size()), 0);
        check("drain_credits", 32'(credits), 4);
        check("drain_idle", 32'(idle), 1);
        check("drain_err", 32'(err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
